key_encoder8_3: RTL and testbench

KEY_ENCODER8_3 -- requirements
Module: key_encoder8_3

---
 rtl/key_encoder8_3.sv | 194 +++++++++++++++++++
 tb/tb_key_encoder8_3.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/key_encoder8_3.sv
// -----------------------------------------------------------------------------
// key_encoder8_3
//   Debounced 8-key priority encoder. Raw key lines are synchronized, the
//   highest pressed index is taken as the candidate, and the code is accepted
//   only after the pressed pattern stays unchanged for CNT_MAX cycles. After
//   acceptance a full debounced release is needed before a new press counts.
//
//   Optional feature: define KEY_ENC_MULTI_ERR_EN to add the multi_err output.
//   When it is defined, a debounced press with more than one key set pulses
//   multi_err instead of code_vld and leaves code unchanged. When it is not
//   defined, multi-key presses resolve to the highest index.
// -----------------------------------------------------------------------------
module key_encoder8_3 #(
  parameter logic [19:0] CNT_MAX = 20'd1_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] key_in,
  output logic [2:0] code,
  output logic       code_vld,
`ifdef KEY_ENC_MULTI_ERR_EN
  output logic       key_held,
  output logic       multi_err
`else
  output logic       key_held
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Last count value before a window is complete; also the saturation point.
  localparam logic [19:0] CNT_LAST = CNT_MAX - 20'd1;

  logic [7:0]  key_meta;
  logic [7:0]  key_sync;
  logic [2:0]  cand_enc;

  state_t      state,     state_nxt;
  logic [19:0] cnt,       cnt_nxt;
  logic [19:0] cnt_inc;
  logic [7:0]  pat,       pat_nxt;
  logic [2:0]  cand,      cand_nxt;
  logic [2:0]  code_nxt;
  logic        vld_nxt;
`ifdef KEY_ENC_MULTI_ERR_EN
  logic        merr_nxt;
  logic        pat_multi;
`endif

  // Two-flop synchronizer for the asynchronous key lines.
  // NOTE: asynchronous active-low reset in the sensitivity list; sequential
  // state is always assigned with non-blocking (<=) so every flop samples the
  // pre-edge values of the others.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_meta <= 8'h00;
      key_sync <= 8'h00;
    end else begin
      key_meta <= key_in;
      key_sync <= key_meta;
    end
  end

  // Priority encode of the synchronized keys: highest set index wins.
  // NOTE: every variable written in an always_comb gets a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cand_enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (key_sync[i]) cand_enc = i[2:0];
    end
  end

  // Counter never wraps: it holds at CNT_LAST until the FSM clears it.
  assign cnt_inc = (cnt >= CNT_LAST) ? CNT_LAST : cnt + 20'd1;

`ifdef KEY_ENC_MULTI_ERR_EN
  // More than one bit set in the latched pattern.
  assign pat_multi = (pat & (pat - 8'd1)) != 8'h00;
`endif

  // Next-state, counter and output decisions.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pat_nxt   = pat;
    cand_nxt  = cand;
    code_nxt  = code;
    vld_nxt   = 1'b0;
`ifdef KEY_ENC_MULTI_ERR_EN
    merr_nxt  = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        if (key_sync != 8'h00) begin
          state_nxt = DEBOUNCE;
          pat_nxt   = key_sync;
          cand_nxt  = cand_enc;
          cnt_nxt   = 20'd0;
        end
      end

      DEBOUNCE: begin
        if (key_sync == 8'h00) begin
          // Bounce back to nothing: drop the press.
          state_nxt = IDLE;
          cnt_nxt   = 20'd0;
        end else if (key_sync != pat) begin
          // Pattern moved: restart the stability window on the new pattern.
          pat_nxt   = key_sync;
          cand_nxt  = cand_enc;
          cnt_nxt   = 20'd0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HOLD;
          cnt_nxt   = 20'd0;
`ifdef KEY_ENC_MULTI_ERR_EN
          if (pat_multi) begin
            merr_nxt = 1'b1;
          end else begin
            code_nxt = cand;
            vld_nxt  = 1'b1;
          end
`else
          code_nxt  = cand;
          vld_nxt   = 1'b1;
`endif
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end

      HOLD: begin
        // Pattern changes with any key still down are deliberately ignored.
        if (key_sync == 8'h00) begin
          state_nxt = RELEASE;
          cnt_nxt   = 20'd0;
        end
      end

      RELEASE: begin
        if (key_sync != 8'h00) begin
          // Release was a bounce: still the same held press.
          state_nxt = HOLD;
          cnt_nxt   = 20'd0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = 20'd0;
        end else begin
          cnt_nxt   = cnt_inc;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 20'd0;
      end
    endcase
  end

  // FSM, counter, latched press and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt      <= 20'd0;
      pat      <= 8'h00;
      cand     <= 3'd0;
      code     <= 3'd0;
      code_vld <= 1'b0;
`ifdef KEY_ENC_MULTI_ERR_EN
      multi_err <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pat      <= pat_nxt;
      cand     <= cand_nxt;
      code     <= code_nxt;
      code_vld <= vld_nxt;
`ifdef KEY_ENC_MULTI_ERR_EN
      multi_err <= merr_nxt;
`endif
    end
  end

  // A key counts as held from acceptance until the release is debounced.
  assign key_held = (state == HOLD) || (state == RELEASE);

endmodule

// File: tb/tb_key_encoder8_3.sv
// -----------------------------------------------------------------------------
// tb_key_encoder8_3
//   Directed bench for key_encoder8_3 with CNT_MAX = 4. Inputs are driven and
//   outputs sampled 1 ns after each rising edge. With CNT_MAX = 4 a stable
//   press is accepted on the 7th edge after key_in changes (2 synchronizer
//   edges, 1 IDLE edge, 4 counting edges), and a release needs 7 edges to
//   return to IDLE.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_key_encoder8_3;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [7:0] key_in;
  logic [2:0] code;
  logic       code_vld;
  logic       key_held;
`ifdef KEY_ENC_MULTI_ERR_EN
  logic       multi_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  key_encoder8_3 #(.CNT_MAX(20'd4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .code      (code),
    .code_vld  (code_vld),
`ifdef KEY_ENC_MULTI_ERR_EN
    .key_held  (key_held),
    .multi_err (multi_err)
`else
    .key_held  (key_held)
`endif
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Step n edges, code_vld must stay low.
  task automatic quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, {7'd0, code_vld}, 8'h00);
    end
  endtask

  // code_vld low for n-1 edges, high after edge n with exp_code, low after n+1.
  task automatic pulse_at(input int n, input logic [2:0] exp_code, input string tag);
    quiet(n - 1, {tag, "_early"});
    step();
    check({tag, "_vld"},  {7'd0, code_vld}, 8'h01);
    check({tag, "_code"}, {5'd0, code},     {5'd0, exp_code});
    check({tag, "_held"}, {7'd0, key_held}, 8'h01);
    step();
    check({tag, "_one"},  {7'd0, code_vld}, 8'h00);
  endtask

  // Drop all keys and let the release debounce all the way to IDLE.
  task automatic release_all(input string tag);
    key_in = 8'h00;
    quiet(8, {tag, "_rel"});
    check({tag, "_idle"}, {7'd0, key_held}, 8'h00);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    key_in    = 8'h00;

    // Reset state.
    step();
    step();
    check("rst_code", {5'd0, code},     8'h00);
    check("rst_vld",  {7'd0, code_vld}, 8'h00);
    check("rst_held", {7'd0, key_held}, 8'h00);
`ifdef KEY_ENC_MULTI_ERR_EN
    check("rst_merr", {7'd0, multi_err}, 8'h00);
`endif
    sys_rst_n = 1'b1;
    quiet(3, "idle");

    // Single key 3, then a pattern change while held is ignored.
    key_in = 8'h08;
    pulse_at(7, 3'd3, "k3");
    key_in = 8'h0C;
    quiet(8, "k3_hold_chg");
    check("k3_hold_held", {7'd0, key_held}, 8'h01);
    check("k3_hold_code", {5'd0, code},     8'h03);
    release_all("k3");
    check("k3_code_kept", {5'd0, code}, 8'h03);

    // Short bounce on key 0: never accepted, back to IDLE.
    key_in = 8'h01;
    step();
    step();
    step();
    key_in = 8'h00;
    quiet(8, "bounce");
    check("bounce_held", {7'd0, key_held}, 8'h00);
    check("bounce_code", {5'd0, code},     8'h03);

    // Two keys at once.
`ifdef KEY_ENC_MULTI_ERR_EN
    key_in = 8'h90;
    for (int i = 0; i < 6; i++) begin
      step();
      check("multi_early", {7'd0, multi_err}, 8'h00);
    end
    step();
    check("multi_merr", {7'd0, multi_err}, 8'h01);
    check("multi_vld",  {7'd0, code_vld},  8'h00);
    check("multi_code", {5'd0, code},      8'h03);
    check("multi_held", {7'd0, key_held},  8'h01);
    step();
    check("multi_one",  {7'd0, multi_err}, 8'h00);
    quiet(4, "multi_hold");
`else
    key_in = 8'h90;
    pulse_at(7, 3'd7, "prio");
`endif
    release_all("multi");

    // Key 2, short release and re-press stays held, then full release, key 6.
    key_in = 8'h04;
    pulse_at(7, 3'd2, "k2");
    key_in = 8'h00;
    step();
    step();
    key_in = 8'h04;
    quiet(10, "k2_repress");
    check("k2_repress_held", {7'd0, key_held}, 8'h01);
    release_all("k2");
    key_in = 8'h40;
    pulse_at(7, 3'd6, "k6");
    release_all("k6");

    // Key 1 changes to key 7 just as the window reaches cnt=2: restart.
    key_in = 8'h02;
    quiet(3, "k1_start");
    key_in = 8'h80;
    pulse_at(7, 3'd7, "k7_restart");
    release_all("k7");

    // Reset in the middle of debouncing key 5.
    key_in = 8'h20;
    quiet(4, "k5_deb");
    #3;
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_code", {5'd0, code},     8'h00);
    check("mid_rst_vld",  {7'd0, code_vld}, 8'h00);
    check("mid_rst_held", {7'd0, key_held}, 8'h00);
    step();
    step();
    check("in_rst_vld", {7'd0, code_vld}, 8'h00);
    sys_rst_n = 1'b1;
    pulse_at(7, 3'd5, "k5_after_rst");
    release_all("k5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
